// File: rtl/imem_pkg.sv
// Shared types, constants and response-forming helper for the instruction-memory responder.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam int unsigned CNT_W     = 4;

    typedef struct packed {
        logic [15:0] instr;
        logic        err;
    } rsp_t;

    // Misaligned, out-of-range or parity-bad fetches return a NOP flagged as an error.
    function automatic rsp_t make_rsp(input logic [15:0] addr, input logic [15:0] data,
                                      input logic par_bad, input int unsigned depth);
        rsp_t r;
        r.err   = addr[0] || (32'(addr[15:1]) >= depth) || par_bad;
        r.instr = r.err ? NOP_INSTR : data;
        return r;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction store: synchronous write, combinational read.
// With IMEM_PARITY_EN defined each word carries an even-parity bit checked on read.
module imem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_idx,
    input  logic [15:0]   wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [15:0]   rd_data,
    output logic          rd_par_bad
);

`ifdef IMEM_PARITY_EN
    logic [16:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= {^wr_data, wr_data};
        end
    end

    always_comb begin
        rd_data    = mem[rd_idx][15:0];
        rd_par_bad = ^mem[rd_idx];
    end
`else
    logic [15:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_data    = mem[rd_idx];
        rd_par_bad = 1'b0;
    end
`endif

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: fixed-latency reads with response backpressure and flush.
// Optional stored-parity checking is enabled by defining IMEM_PARITY_EN.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_instr,
    output logic        rsp_err,
    input  logic        ld_we,
    input  logic [15:0] ld_addr,
    input  logic [15:0] ld_data
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("imem_responder: LATENCY must be in 1..15");
    end
    if (DEPTH_WORDS < 1 || DEPTH_WORDS > 32768) begin : g_bad_depth
        $error("imem_responder: DEPTH_WORDS must be in 1..32768");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      addr_q;
    logic [15:0]      data_q;
    logic             par_q;
    logic [15:0]      rd_data;
    logic             rd_par_bad;
    logic             accept;
    logic             ld_en;
    logic             unused_ld_lsb;
    rsp_t             acc_rsp;
    rsp_t             pend_rsp;

    assign req_ready     = !flush && (state == IDLE || (state == RESP && rsp_ready));
    assign accept        = req_valid && req_ready;
    assign ld_en         = ld_we && (state == IDLE) && (32'(ld_addr[15:1]) < DEPTH_WORDS);
    assign unused_ld_lsb = ld_addr[0];
    assign acc_rsp       = make_rsp(req_addr, rd_data, rd_par_bad, DEPTH_WORDS);
    assign pend_rsp      = make_rsp(addr_q, data_q, par_q, DEPTH_WORDS);

    // Word data is sampled at accept so a same-cycle load of that word is not visible.
    imem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk       (clk),
        .we        (ld_en),
        .wr_idx    (ld_addr[AW:1]),
        .wr_data   (ld_data),
        .rd_idx    (req_addr[AW:1]),
        .rd_data   (rd_data),
        .rd_par_bad(rd_par_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_instr <= NOP_INSTR;
            rsp_err   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= req_addr;
                data_q <= rd_data;
                par_q  <= rd_par_bad;
                cnt    <= CNT_W'(LATENCY - 1);
            end
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        if (LATENCY == 1) begin
                            state                <= RESP;
                            rsp_valid            <= 1'b1;
                            {rsp_instr, rsp_err} <= acc_rsp;
                        end else begin
                            state     <= BUSY;
                            rsp_valid <= 1'b0;
                        end
                    end else if (state == RESP && rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state                <= RESP;
                        rsp_valid            <= 1'b1;
                        {rsp_instr, rsp_err} <= pend_rsp;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
